// File: rtl/pixel_column_feeder_pkg.sv
// Shared definitions for the pixel column feeder: pixel/lane geometry,
// the frame sequencing state type and a small constant-math helper.
package pixel_column_feeder_pkg;

  localparam int PIX_W = 8;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } feederState_t;

  // Integer ceiling division for elaboration-time constants.
  function automatic int ceilDiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/pixel_column_feeder_skid_fifo.sv
// Two-entry skid buffer that holds returned memory words until the
// downstream consumer takes them. The head entry stays put while no pop
// occurs, so the presented column is stable during back-pressure.
module feeder_skid_fifo
  import pixel_column_feeder_pkg::*;
#(
  parameter int DATA_W = LANES * PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] slot_q [2];
  logic              wrPtr_q;
  logic              rdPtr_q;
  logic [1:0]        count_q;

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_i) begin
        slot_q[wrPtr_q] <= data_i;
        wrPtr_q         <= ~wrPtr_q;
      end
      if (pop_i) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = slot_q[rdPtr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/pixel_column_feeder.sv
// Pixel column feeder: walks an image in horizontal bands of four rows,
// reading one 4-pixel column per request from memory and handing the
// columns downstream with valid/ready flow control.
// Optional build macro PIXEL_FEEDER_PAD_EN: lanes below the bottom image
// row are forced to zero and the band count extends to cover the last rows.
module pixel_column_feeder
  import pixel_column_feeder_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ROW_STEP   = 2,
  parameter int ADDR_W     = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_go,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [LANES*PIX_W-1:0]   mem_rdata,
  output logic [PIX_W-1:0]         pixel_in1,
  output logic [PIX_W-1:0]         pixel_in2,
  output logic [PIX_W-1:0]         pixel_in3,
  output logic [PIX_W-1:0]         pixel_in4,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic                     start,
  output logic                     frame_done
);

`ifdef PIXEL_FEEDER_PAD_EN
  localparam int NUM_BANDS = ceilDiv(IMG_HEIGHT - 2, ROW_STEP);
  localparam int ROW_W     = $clog2(IMG_HEIGHT + ROW_STEP + LANES + 1);
`else
  localparam int NUM_BANDS = (IMG_HEIGHT - LANES) / ROW_STEP + 1;
`endif
  localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [ADDR_W-1:0] BAND_STRIDE = ADDR_W'(ROW_STEP * IMG_WIDTH);
  localparam logic [COL_W-1:0]  LAST_COL    = COL_W'(IMG_WIDTH - 1);
  localparam logic [BAND_W-1:0] LAST_BAND   = BAND_W'(NUM_BANDS - 1);

  feederState_t        state_q;
  logic [COL_W-1:0]    col_q;
  logic [BAND_W-1:0]   band_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   bandBase_q;
  logic                rdPend_q;
  logic                start_q;
  logic                frame_done_q;
`ifdef PIXEL_FEEDER_PAD_EN
  logic [ROW_W-1:0]    rowBase_q;
  logic [ROW_W-1:0]    pendRowBase_q;
`endif

  logic [LANES*PIX_W-1:0] pushData;
  logic [LANES*PIX_W-1:0] headData;
  logic                   fifoValid;
  logic [1:0]             fifoCount;
  logic                   fire;
  logic [1:0]             occNext;
  logic                   issueRead;
  logic                   colWrap;
  logic                   lastRead;

  // Read credit: a new read lands two edges from now, so it is safe when the
  // buffer occupancy after this edge (including the read already returning)
  // leaves at least one slot for it even if nothing is popped meanwhile.
  always_comb begin
    fire      = fifoValid & col_ready;
    occNext   = fifoCount - {1'b0, fire} + {1'b0, rdPend_q};
    issueRead = (state_q == RUN) && (occNext <= 2'd1);
    colWrap   = (col_q == LAST_COL);
    lastRead  = issueRead && colWrap && (band_q == LAST_BAND);
  end

  // Returned word conditioning before it enters the buffer.
  always_comb begin
    pushData = mem_rdata;
`ifdef PIXEL_FEEDER_PAD_EN
    for (int k = 0; k < LANES; k++) begin
      if ((pendRowBase_q + ROW_W'(k)) >= ROW_W'(IMG_HEIGHT)) begin
        pushData[k*PIX_W +: PIX_W] = '0;
      end
    end
`endif
  end

  // Frame sequencer with column/band scan counters and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= '0;
      band_q        <= '0;
      addr_q        <= '0;
      bandBase_q    <= '0;
      rdPend_q      <= 1'b0;
      start_q       <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef PIXEL_FEEDER_PAD_EN
      rowBase_q     <= '0;
      pendRowBase_q <= '0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      rdPend_q     <= issueRead;
`ifdef PIXEL_FEEDER_PAD_EN
      pendRowBase_q <= rowBase_q;
`endif
      if (fire) begin
        start_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (frame_go) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issueRead) begin
            if (colWrap) begin
              col_q      <= '0;
              band_q     <= band_q + BAND_W'(1);
              bandBase_q <= bandBase_q + BAND_STRIDE;
              addr_q     <= bandBase_q + BAND_STRIDE;
`ifdef PIXEL_FEEDER_PAD_EN
              rowBase_q  <= rowBase_q + ROW_W'(ROW_STEP);
`endif
            end else begin
              col_q  <= col_q + COL_W'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end
            if (lastRead) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (occNext == 2'd0) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            start_q      <= 1'b0;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          col_q      <= '0;
          band_q     <= '0;
          addr_q     <= '0;
          bandBase_q <= '0;
`ifdef PIXEL_FEEDER_PAD_EN
          rowBase_q  <= '0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  feeder_skid_fifo #(
    .DATA_W(LANES * PIX_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (rdPend_q),
    .data_i (pushData),
    .pop_i  (fire),
    .data_o (headData),
    .valid_o(fifoValid),
    .count_o(fifoCount)
  );

  assign mem_addr   = addr_q;
  assign mem_rd     = issueRead;
  assign col_valid  = fifoValid;
  assign pixel_in1  = headData[0*PIX_W +: PIX_W];
  assign pixel_in2  = headData[1*PIX_W +: PIX_W];
  assign pixel_in3  = headData[2*PIX_W +: PIX_W];
  assign pixel_in4  = headData[3*PIX_W +: PIX_W];
  assign start      = start_q | fire;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_column_feeder.sv
// Scoreboard bench for pixel_column_feeder on a tiny 4-pixel-wide image.
// Expected columns and addresses are queued when a frame is launched and
// consumed as the design issues reads and hands columns downstream.
module tb_pixel_column_feeder;

  localparam int W  = 4;
`ifdef PIXEL_FEEDER_PAD_EN
  localparam int H  = 5;
  localparam int NB = (H - 2 + 2 - 1) / 2;
`else
  localparam int H  = 6;
  localparam int NB = (H - 4) / 2 + 1;
`endif
  localparam int RS    = 2;
  localparam int AW    = 19;
  localparam int TOTAL = NB * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_go;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_rdata = 32'h0;
  logic [7:0]    pixel_in1, pixel_in2, pixel_in3, pixel_in4;
  logic          col_valid;
  logic          col_ready;
  logic          start;
  logic          frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int goCyc       = 0;
  int riseCyc     = -1;
  int lastAccept  = -1;
  int totalAccept = 0;
  int acceptBase  = 0;
  int doneCnt     = 0;
  int doneBefore  = 0;
  logic        stallPrev = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] stallData = 32'h0;
  logic [31:0] colQ[$];
  int          addrQ[$];

  pixel_column_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .ROW_STEP  (RS),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_go  (frame_go),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .pixel_in1 (pixel_in1),
    .pixel_in2 (pixel_in2),
    .pixel_in3 (pixel_in3),
    .pixel_in4 (pixel_in4),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .start     (start),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input int a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'((a + k * W) % 256);
    return w;
  endfunction

  function automatic logic [31:0] expCol(input int b, input int c);
    logic [31:0] w;
    w = memWord(b * RS * W + c);
`ifdef PIXEL_FEEDER_PAD_EN
    for (int k = 0; k < 4; k++) if (b * RS + k >= H) w[k*8 +: 8] = 8'h00;
`endif
    return w;
  endfunction

  // Memory answers one cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= memWord(int'(mem_addr));
    else        mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue a full frame of expectations, then pulse frame_go for one cycle.
  task automatic applyStimulus();
    for (int b = 0; b < NB; b++)
      for (int c = 0; c < W; c++) begin
        colQ.push_back(expCol(b, c));
        addrQ.push_back(b * RS * W + c);
      end
    acceptBase = totalAccept;
    @(posedge clk); #1;
    frame_go = 1'b1;
    goCyc    = cyc;
    @(posedge clk); #1;
    frame_go = 1'b0;
  endtask

  // Drive col_ready each cycle until frame_done has been seen or budget ends.
  task automatic runFrame(input bit toggle, input bit spuriousGo, input int budget);
    int d0;
    d0 = doneCnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      col_ready = toggle ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      frame_go  = spuriousGo && (i == 4);
      if (doneCnt != d0) break;
    end
    col_ready = 1'b1;
    frame_go  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("frame_done_once", 32'(doneCnt - d0), 32'd1);
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({pfx, "_mem_rd"}, 32'(mem_rd), 32'd0);
    checkOutput({pfx, "_col_valid"}, 32'(col_valid), 32'd0);
    checkOutput({pfx, "_start"}, 32'(start), 32'd0);
    checkOutput({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({pfx, "_pixels"}, {pixel_in4, pixel_in3, pixel_in2, pixel_in1}, 32'd0);
  endtask

  // Monitor: scoreboard pops, stall hold, start window and done spacing.
  always @(negedge clk) begin
    logic [31:0] cur;
    logic        fire;
    int          inFrame;
    if (rst) begin
      stallPrev = 1'b0;
      prevValid = 1'b0;
    end else begin
      cur     = {pixel_in4, pixel_in3, pixel_in2, pixel_in1};
      fire    = col_valid && col_ready;
      inFrame = totalAccept - acceptBase;
      checkOutput("start", 32'(start), 32'(fire || (inFrame > 0 && inFrame < TOTAL)));
      if (mem_rd) begin
        checkOutput("addr_expected", 32'(addrQ.size() != 0), 32'd1);
        if (addrQ.size() != 0) checkOutput("mem_addr", 32'(mem_addr), 32'(addrQ.pop_front()));
      end
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(col_valid), 32'd1);
        checkOutput("stall_hold", cur, stallData);
      end
      if (col_valid && !prevValid) riseCyc = cyc;
      if (fire) begin
        checkOutput("col_expected", 32'(colQ.size() != 0), 32'd1);
        if (colQ.size() != 0) checkOutput($sformatf("column%0d", inFrame), cur, colQ.pop_front());
        lastAccept = cyc;
        totalAccept++;
      end
      if (frame_done) begin
        doneCnt++;
        checkOutput("done_after_last", 32'(cyc - lastAccept), 32'd1);
      end
      stallPrev = col_valid && !col_ready;
      stallData = cur;
      prevValid = col_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit hit;
    rst       = 1'b1;
    frame_go  = 1'b0;
    col_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Frame A: ready held high, full-rate streaming.
    $display("[TB] frame A: col_ready held high");
    applyStimulus();
    runFrame(1'b0, 1'b0, 200);
    checkOutput("latencyA", 32'(riseCyc - goCyc), 32'd3);
    checkOutput("gaplessA", 32'(lastAccept - riseCyc), 32'(TOTAL - 1));
    checkOutput("countA", 32'(totalAccept - acceptBase), 32'(TOTAL));
    checkOutput("colQ_emptyA", 32'(colQ.size()), 32'd0);
    checkOutput("addrQ_emptyA", 32'(addrQ.size()), 32'd0);

    // Frame B: ready toggles 1,0,0,1 and a stray frame_go arrives mid-run.
    $display("[TB] frame B: col_ready toggling, stray frame_go");
    applyStimulus();
    runFrame(1'b1, 1'b1, 400);
    checkOutput("countB", 32'(totalAccept - acceptBase), 32'(TOTAL));
    checkOutput("colQ_emptyB", 32'(colQ.size()), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_no_valid", 32'(col_valid), 32'd0);
    checkOutput("idle_no_rd", 32'(mem_rd), 32'd0);
    checkOutput("countB_after", 32'(totalAccept - acceptBase), 32'(TOTAL));

    // Frame C: reset on the fourth accepted column.
    $display("[TB] frame C: reset mid-frame");
    applyStimulus();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (totalAccept - acceptBase >= 4) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("reached_4th_accept", 32'(hit), 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    colQ.delete();
    addrQ.delete();
    doneBefore = doneCnt;
    @(posedge clk);
    @(posedge clk); #1;
    rst        = 1'b0;
    acceptBase = totalAccept;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(doneCnt - doneBefore), 32'd0);
    checkOutput("abort_idle_valid", 32'(col_valid), 32'd0);
    checkOutput("abort_idle_rd", 32'(mem_rd), 32'd0);

    // Frame D: clean restart from address 0.
    $display("[TB] frame D: restart after abort");
    applyStimulus();
    runFrame(1'b0, 1'b0, 200);
    checkOutput("latencyD", 32'(riseCyc - goCyc), 32'd3);
    checkOutput("countD", 32'(totalAccept - acceptBase), 32'(TOTAL));
    checkOutput("colQ_emptyD", 32'(colQ.size()), 32'd0);
    checkOutput("addrQ_emptyD", 32'(addrQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
